// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, states,
// ALU operations and datapath select values.
package control_pkg;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_LW    = 4'd2;
    localparam logic [3:0] OP_SW    = 4'd3;
    localparam logic [3:0] OP_BEQ   = 4'd4;
    localparam logic [3:0] OP_BNE   = 4'd5;
    localparam logic [3:0] OP_J     = 4'd6;
    localparam logic [3:0] OP_JAL   = 4'd7;
    localparam logic [3:0] OP_JR    = 4'd8;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_WB_R      = 4'd3,
        S_EXEC_I    = 4'd4,
        S_WB_I      = 4'd5,
        S_MEM_ADDR  = 4'd6,
        S_MEM_READ  = 4'd7,
        S_MEM_WRITE = 4'd8,
        S_MEM_WB    = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JAL       = 4'd12,
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        S_JR        = 4'd13,
        S_HALT      = 4'd14
`else
        S_JR        = 4'd13
`endif
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] REGDST_RT   = 2'd0;
    localparam logic [1:0] REGDST_RD   = 2'd1;
    localparam logic [1:0] REGDST_LINK = 2'd2;

    localparam logic [1:0] MEMTOREG_ALU = 2'd0;
    localparam logic [1:0] MEMTOREG_MDR = 2'd1;
    localparam logic [1:0] MEMTOREG_PC  = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    localparam logic [1:0] SRCB_B     = 2'd0;
    localparam logic [1:0] SRCB_ONE   = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_BROFF = 2'd3;

endpackage

// File: rtl/control_next_state.sv
// Combinational next-state logic for the multicycle control FSM.
// Illegal opcodes go to HALT when MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN is set.
module control_next_state
    import control_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  state_t              state,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output state_t              next_state
);

    // Opcode dispatch out of DECODE
    state_t decode_target;

    // Pick the execute-phase state for the current opcode
    always_comb begin
        decode_target = S_FETCH;
        case (opcode)
            OP_RTYPE: decode_target = S_EXEC_R;
            OP_ADDI:  decode_target = S_EXEC_I;
            OP_LW:    decode_target = S_MEM_ADDR;
            OP_SW:    decode_target = S_MEM_ADDR;
            OP_BEQ:   decode_target = S_BRANCH;
            OP_BNE:   decode_target = S_BRANCH;
            OP_J:     decode_target = S_JUMP;
            OP_JAL:   decode_target = S_JAL;
            OP_JR:    decode_target = S_JR;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            default:  decode_target = S_HALT;
`else
            default:  decode_target = S_FETCH;
`endif
        endcase
    end

    // State transition table; unknown encodings fall back to FETCH
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:
                next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:
                next_state = decode_target;
            S_EXEC_R:
                next_state = S_WB_R;
            S_EXEC_I:
                next_state = S_WB_I;
            S_MEM_ADDR:
                next_state = (opcode == OP_LW) ? S_MEM_READ
                                               : S_MEM_WRITE;
            S_MEM_READ:
                next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE:
                next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            S_HALT:
                next_state = S_HALT;
`endif
            default:
                next_state = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for the multicycle 16-bit datapath: state register + output decode.
// Optional MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN adds HALT and the halted port.
module multicycle_control
    import control_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int STATE_W  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic [1:0]          reg_dst_sel,
    output logic [1:0]          mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    output logic                halted,
`endif
    output logic [STATE_W-1:0]  state_out
);

    state_t state;
    state_t next_state;

    control_next_state #(
        .OPCODE_W (OPCODE_W)
    ) u_next (
        .state      (state),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .next_state (next_state)
    );

    // State register; reset pulls back to FETCH immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    assign state_out = STATE_W'(state);

    // Per-state datapath controls; write strobes are squashed during reset
    always_comb begin
        pc_write    = 1'b0;
        pc_src      = PCSRC_ALU;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst_sel = REGDST_RT;
        mem_to_reg  = MEMTOREG_ALU;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_B;
        alu_op      = ALUOP_ADD;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        halted      = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_ONE;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_BROFF;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_WB_R: begin
                reg_write   = 1'b1;
                reg_dst_sel = REGDST_RD;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_WB_I: begin
                reg_write = 1'b1;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = MEMTOREG_MDR;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_write  = (opcode == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            S_JAL: begin
                reg_write   = 1'b1;
                reg_dst_sel = REGDST_LINK;
                mem_to_reg  = MEMTOREG_PC;
                pc_src      = PCSRC_JUMP;
                pc_write    = 1'b1;
            end
            S_JR: begin
                pc_src   = PCSRC_REG;
                pc_write = 1'b1;
            end
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            S_HALT: begin
                halted = 1'b1;
            end
`endif
            default: begin
                pc_write = 1'b0;
            end
        endcase
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
            mem_read  = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM for the multicycle 16-bit datapath, 8 registers, 3-bit register addresses.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath mux select and write enable.
- reg_dst_sel feeds the 3-input 3-bit destination-register mux directly: 0 = rt field, 1 = rd field, 2 = link register.

Parameters:
- OPCODE_W, 4, instruction opcode width.
- STATE_W, 4, state register width; must hold all states.

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high; forces FETCH
- opcode  in  OPCODE_W  IR[15:12], valid from DECODE onward
- zero  in  1  ALU zero flag, sampled in BRANCH
- mem_ready  in  1  memory handshake; access completes on the cycle it is high
- pc_write  out  1  PC load enable
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = register A
- iord  out  1  0 = PC address, 1 = ALUOut address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load enable
- reg_write  out  1  register file write enable
- reg_dst_sel  out  2  0 = rt, 1 = rd, 2 = link; 3 never driven
- mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC; 3 never driven
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  0 = B, 1 = constant 1, 2 = sign-extended imm, 3 = sign-extended imm (branch offset)
- alu_op  out  2  0 = add, 1 = sub, 2 = funct-decoded
- state_out  out  STATE_W  current state, for debug

Behaviour:
- Reset: state = FETCH, asynchronous.
  - While reset is high: pc_write, ir_write, reg_write and mem_write are forced 0; mem_read is forced 0.
  - All unlisted outputs are 0 in every state.
- Opcodes: 0 R-type, 1 addi, 2 lw, 3 sw, 4 beq, 5 bne, 6 j, 7 jal, 8 jr, 9-15 illegal.
- FETCH:
  - Outputs: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 1, alu_op = add, pc_src = 0.
  - ir_write and pc_write are asserted only in the cycle mem_ready = 1.
  - Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 3, alu_op = add (precomputes branch target).
  - Next state by opcode: 0 -> EXEC_R, 1 -> EXEC_I, 2/3 -> MEM_ADDR, 4/5 -> BRANCH, 6 -> JUMP, 7 -> JAL, 8 -> JR, illegal -> FETCH.
- EXEC_R: alu_src_a = 1, alu_src_b = 0, alu_op = 2; next WB_R.
- WB_R: reg_write = 1, reg_dst_sel = 1, mem_to_reg = 0; next FETCH.
- EXEC_I: alu_src_a = 1, alu_src_b = 2, alu_op = add; next WB_I.
- WB_I: reg_write = 1, reg_dst_sel = 0, mem_to_reg = 0; next FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, alu_op = add; next MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read = 1, iord = 1; hold until mem_ready, then MEM_WB.
- MEM_WRITE: mem_write = 1, iord = 1; hold until mem_ready, then FETCH.
  - mem_write stays high for every wait cycle.
- MEM_WB: reg_write = 1, reg_dst_sel = 0, mem_to_reg = 1; next FETCH.
- BRANCH:
  - Outputs: alu_src_a = 1, alu_src_b = 0, alu_op = sub, pc_src = 1.
  - pc_write = zero for beq, ~zero for bne. This is the only Mealy output.
  - Next FETCH.
- JUMP: pc_src = 2, pc_write = 1; next FETCH.
- JAL: reg_write = 1, reg_dst_sel = 2, mem_to_reg = 2, pc_src = 2, pc_write = 1; next FETCH.
  - The PC value written to the link register is the already-incremented PC.
- JR: pc_src = 3, pc_write = 1; next FETCH.
- Cycle counts with zero wait states: R/addi 4, lw 5, sw 4, beq/bne/j/jal/jr 3. Each mem_ready = 0 cycle adds one.
- Reset mid-instruction: the in-flight instruction is abandoned with no register or memory write after reset asserts; execution restarts at FETCH.
- Unreachable state encodings recover to FETCH on the next clock.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE goes to HALT.
  - HALT drives all enables 0 and asserts the extra output port halted (1 bit).
  - HALT is left only by reset.
- Undefined: illegal opcodes behave as NOP (DECODE -> FETCH); no halted port, no HALT state.

Decomposition:
- Shared package control_pkg holds:
  - opcode constants (OP_RTYPE..OP_JR);
  - state encodings;
  - ALU op encodings (ALUOP_ADD/SUB/FUNCT);
  - select encodings (REGDST_RT/RD/LINK, MEMTOREG_ALU/MDR/PC, PCSRC_*).
- Sub-module control_next_state: purely combinational next-state logic, taking state, opcode and mem_ready.
- The top module keeps the state register and the output decode.

Test Plan:
- Reset mid-WB_R, with reset asserted between clock edges -> reg_write drops immediately; state_out = FETCH; no write occurs.
- addi with mem_ready tied 1 -> 4 cycles; reg_write = 1 with reg_dst_sel = 0 and mem_to_reg = 0 exactly in cycle 4.
- lw with mem_ready low for 2 cycles in MEM_READ -> 7 cycles total; mem_read and iord held high throughout the wait.
- beq with zero = 1, then bne with zero = 1 -> pc_write = 1 in BRANCH for beq, 0 for bne; both take 3 cycles.
- jal -> in cycle 3, reg_write = 1, reg_dst_sel = 2, mem_to_reg = 2, pc_src = 2, pc_write = 1.
- opcode 12 -> without the macro, state returns to FETCH after DECODE; with the macro, halted = 1 and stays 1 until reset.
